// File: rtl/dqsw_wrlvl_train_ctrl.sv
// dqsw_wrlvl_train_ctrl -- write-leveling training controller for one DDR3 DQSW lane.
// Sweeps the DQSW output delay upward from tap 0 and looks for the first tap
// with stable DQ feedback of 1 that comes after at least one tap reading 0.
// The delay line is left parked at that tap.
// Optional debug visibility: define DQSW_WRLVL_TRAIN_DBG_EN to add the
// DBG_STATE and DBG_TAP outputs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for TRAIN_START
// LOAD   | delay line reset to tap 0, eye monitor flags cleared
// SETTLE | delay line settling after LOAD/MOVE
// PULSE  | one DQS pulse driven to the IOD
// WAIT   | waiting for the pulse's RX_DATA to become valid
// SAMPLE | accumulate RX_DATA_0[0] for this pulse
// EVAL   | decide whether the current tap is stable 1 or 0
// STEP   | advance one tap, or stop at end of range
// DONE   | edge found, TAP_RESULT valid, delay line parked
// ERR    | sweep ran out of taps or the delay line saturated
module dqsw_wrlvl_train_ctrl #(
  parameter int TAP_W           = 7,
  parameter int TAP_MAX         = 127,
  parameter int SETTLE_CYCLES   = 8,
  parameter int SAMPLES_PER_TAP = 4,
  parameter int RX_LAT          = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             TRAIN_START,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [TAP_W-1:0] TAP_RESULT,
  output logic [1:0]       TX_DATA_0,
  output logic [1:0]       OE_DATA_0,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  output logic             EYE_MONITOR_CLEAR_FLAGS_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0,
  input  logic [1:0]       RX_DATA_0
`ifdef DQSW_WRLVL_TRAIN_DBG_EN
  ,
  output logic [3:0]       DBG_STATE,
  output logic [TAP_W-1:0] DBG_TAP
`endif
);

  // One down-counter serves both the settle wait and the RX latency wait.
  localparam int TMR_MAX = (SETTLE_CYCLES > RX_LAT) ? SETTLE_CYCLES : RX_LAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SMP_W   = $clog2(SAMPLES_PER_TAP + 1);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LD   = TMR_W'((RX_LAT > 1) ? (RX_LAT - 2) : 0);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(SAMPLES_PER_TAP - 1);
  localparam logic [SMP_W-1:0] SMP_ALL   = SMP_W'(SAMPLES_PER_TAP);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAP_MAX);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_SETTLE = 4'd2,
    S_PULSE  = 4'd3,
    S_WAIT   = 4'd4,
    S_SAMPLE = 4'd5,
    S_EVAL   = 4'd6,
    S_STEP   = 4'd7,
    S_DONE   = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  state_t           state;
  logic [TAP_W-1:0] tap;
  logic [TMR_W-1:0] tmr;
  logic [SMP_W-1:0] pulse_cnt;
  logic [SMP_W-1:0] ones_cnt;
  logic             seen_zero;

  // Only bit 0 of the feedback carries the leveling result.
  logic unused_rx_hi;
  assign unused_rx_hi = RX_DATA_0[1];

  // Training sequencer: state, counters and all registered outputs.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state                     <= S_IDLE;
      tap                       <= '0;
      tmr                       <= '0;
      pulse_cnt                 <= '0;
      ones_cnt                  <= '0;
      seen_zero                 <= 1'b0;
      TRAIN_BUSY                <= 1'b0;
      TRAIN_DONE                <= 1'b0;
      TRAIN_ERR                 <= 1'b0;
      TAP_RESULT                <= '0;
      TX_DATA_0                 <= 2'b00;
      OE_DATA_0                 <= 2'b00;
      DELAY_LINE_LOAD_0         <= 1'b0;
      DELAY_LINE_MOVE_0         <= 1'b0;
      DELAY_LINE_DIRECTION_0    <= 1'b1;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
    end else begin
      // Pulse-type outputs default low; the sweep only ever increments.
      TX_DATA_0                 <= 2'b00;
      OE_DATA_0                 <= 2'b00;
      DELAY_LINE_LOAD_0         <= 1'b0;
      DELAY_LINE_MOVE_0         <= 1'b0;
      DELAY_LINE_DIRECTION_0    <= 1'b1;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (TRAIN_START) begin
            state                     <= S_LOAD;
            tap                       <= '0;
            seen_zero                 <= 1'b0;
            TRAIN_BUSY                <= 1'b1;
            TRAIN_DONE                <= 1'b0;
            TRAIN_ERR                 <= 1'b0;
            TAP_RESULT                <= '0;
            DELAY_LINE_LOAD_0         <= 1'b1;
            EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
          end
        end
        S_LOAD: begin
          state     <= S_SETTLE;
          tmr       <= SETTLE_LD;
          pulse_cnt <= '0;
          ones_cnt  <= '0;
        end
        S_SETTLE: begin
          if (tmr == '0) begin
            state     <= S_PULSE;
            TX_DATA_0 <= 2'b01;
            OE_DATA_0 <= 2'b11;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_PULSE: begin
          // With RX_LAT of 1 the feedback is already valid on the next cycle.
          if (RX_LAT > 1) begin
            state <= S_WAIT;
            tmr   <= WAIT_LD;
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_WAIT: begin
          if (tmr == '0) state <= S_SAMPLE;
          else           tmr   <= tmr - TMR_W'(1);
        end
        S_SAMPLE: begin
          ones_cnt  <= ones_cnt + SMP_W'(RX_DATA_0[0]);
          pulse_cnt <= pulse_cnt + SMP_W'(1);
          if (pulse_cnt == SMP_LAST) begin
            state <= S_EVAL;
          end else begin
            state     <= S_PULSE;
            TX_DATA_0 <= 2'b01;
            OE_DATA_0 <= 2'b11;
          end
        end
        S_EVAL: begin
          // A tap only counts as 1 if every pulse read back 1.
          if (ones_cnt != SMP_ALL) begin
            seen_zero <= 1'b1;
            state     <= S_STEP;
          end else if (seen_zero) begin
            TAP_RESULT <= tap;
            TRAIN_DONE <= 1'b1;
            TRAIN_BUSY <= 1'b0;
            state      <= S_DONE;
          end else begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          if ((tap == TAP_LAST) || DELAY_LINE_OUT_OF_RANGE_0) begin
            TAP_RESULT <= tap;
            TRAIN_ERR  <= 1'b1;
            TRAIN_BUSY <= 1'b0;
            state      <= S_ERR;
          end else begin
            DELAY_LINE_MOVE_0 <= 1'b1;
            tap               <= tap + TAP_W'(1);
            tmr               <= SETTLE_LD;
            pulse_cnt         <= '0;
            ones_cnt          <= '0;
            state             <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DQSW_WRLVL_TRAIN_DBG_EN
  // Debug taps straight off the state and tap registers.
  assign DBG_STATE = state;
  assign DBG_TAP   = tap;
`endif

endmodule

// File: tb/tb_dqsw_wrlvl_train_ctrl.sv
// tb_dqsw_wrlvl_train_ctrl -- directed bench with a behavioural DQSW IOD model.
module tb_dqsw_wrlvl_train_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TRAIN_START = 1'b0;
  logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
  logic [6:0] TAP_RESULT;
  logic [1:0] TX_DATA_0, OE_DATA_0;
  logic       DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0;
  logic       EYE_MONITOR_CLEAR_FLAGS_0;
  logic       DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
  logic [1:0] RX_DATA_0 = 2'b00;
`ifdef DQSW_WRLVL_TRAIN_DBG_EN
  logic [3:0] dbg_state;
  logic [6:0] dbg_tap;
`endif

  dqsw_wrlvl_train_ctrl dut (
    .FAB_CLK                   (FAB_CLK),
    .RESET_N                   (RESET_N),
    .TRAIN_START               (TRAIN_START),
    .TRAIN_BUSY                (TRAIN_BUSY),
    .TRAIN_DONE                (TRAIN_DONE),
    .TRAIN_ERR                 (TRAIN_ERR),
    .TAP_RESULT                (TAP_RESULT),
    .TX_DATA_0                 (TX_DATA_0),
    .OE_DATA_0                 (OE_DATA_0),
    .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
    .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
    .EYE_MONITOR_CLEAR_FLAGS_0 (EYE_MONITOR_CLEAR_FLAGS_0),
    .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
    .RX_DATA_0                 (RX_DATA_0)
`ifdef DQSW_WRLVL_TRAIN_DBG_EN
    ,
    .DBG_STATE                 (dbg_state),
    .DBG_TAP                   (dbg_tap)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int n_cmp = 0;
  int n_err = 0;

  // IOD model state
  int m_mode    = 0;
  int m_oor_tap = -1;
  int m_tap     = 0;
  int m_pidx    = 0;
  int load_cnt  = 0;
  int move_cnt  = 0;
  int clr_cnt   = 0;
  int busy_cyc  = 0;
  int both_cnt  = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feedback per mode: 0 -> edge at 37; 1 -> ones 0..9, zeros 10..49, ones from 50;
  // 2 -> always 0; 3 -> tap 37 reads 1,1,0,1 per pulse, ones from 38.
  function automatic logic model_bit(input int mode, input int tap, input int idx);
    case (mode)
      0:       return tap >= 37;
      1:       return (tap <= 9) || (tap >= 50);
      2:       return 1'b0;
      3:       return (tap >= 38) || ((tap == 37) && (idx != 2));
      default: return 1'b0;
    endcase
  endfunction

  // IOD model and pulse counters, evaluated mid-cycle on stable DUT outputs.
  always @(negedge FAB_CLK) begin
    if (DELAY_LINE_LOAD_0) begin
      m_tap = 0;
      m_pidx = 0;
      load_cnt++;
    end
    if (DELAY_LINE_MOVE_0) begin
      m_tap++;
      m_pidx = 0;
      move_cnt++;
    end
    if (EYE_MONITOR_CLEAR_FLAGS_0) clr_cnt++;
    if (TX_DATA_0 == 2'b01 && OE_DATA_0 == 2'b11) begin
      RX_DATA_0 = {1'b0, model_bit(m_mode, m_tap, m_pidx)};
      m_pidx++;
    end
    DELAY_LINE_OUT_OF_RANGE_0 = (m_oor_tap >= 0) && (m_tap >= m_oor_tap);
    if (TRAIN_BUSY) busy_cyc++;
    if (TRAIN_DONE && TRAIN_ERR) both_cnt++;
  end

  task automatic pulse_start();
    @(posedge FAB_CLK);
    #1 TRAIN_START = 1'b1;
    @(posedge FAB_CLK);
    #1 TRAIN_START = 1'b0;
  endtask

  task automatic run_train(input int max_cyc, output bit timeout);
    load_cnt = 0;
    move_cnt = 0;
    clr_cnt  = 0;
    busy_cyc = 0;
    pulse_start();
    timeout = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge FAB_CLK);
      #1;
      if (TRAIN_DONE || TRAIN_ERR) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, int'(TRAIN_BUSY), 0);
    check_val({tag, "_done"}, int'(TRAIN_DONE), 0);
    check_val({tag, "_err"}, int'(TRAIN_ERR), 0);
    check_val({tag, "_tap"}, int'(TAP_RESULT), 0);
    check_val({tag, "_txoe"}, int'({TX_DATA_0, OE_DATA_0}), 0);
    check_val({tag, "_ld_mv_clr"}, int'({DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, EYE_MONITOR_CLEAR_FLAGS_0}), 0);
    check_val({tag, "_dir"}, int'(DELAY_LINE_DIRECTION_0), 1);
  endtask

  initial begin
    bit to;
    int snap_moves;
    bit reached;

    repeat (3) @(posedge FAB_CLK);
    #1 check_reset_outputs("rst");
    RESET_N = 1'b1;
    repeat (2) @(posedge FAB_CLK);

    // Edge at tap 37
    m_mode = 0; m_oor_tap = -1;
    run_train(2000, to);
    check_val("t1_timeout", int'(to), 0);
    check_val("t1_done", int'(TRAIN_DONE), 1);
    check_val("t1_err", int'(TRAIN_ERR), 0);
    check_val("t1_busy", int'(TRAIN_BUSY), 0);
    check_val("t1_tap", int'(TAP_RESULT), 37);
    check_val("t1_moves", move_cnt, 37);
    check_val("t1_loads", load_cnt, 1);
    check_val("t1_clears", clr_cnt, 1);
    check_val("t1_busy_cycles", busy_cyc, 38 * 30);
    repeat (20) @(posedge FAB_CLK);
    #1 check_val("t1_parked_moves", move_cnt, 37);

    // Leading one-region skipped, edge at 50
    m_mode = 1;
    run_train(3000, to);
    check_val("t2_timeout", int'(to), 0);
    check_val("t2_done", int'(TRAIN_DONE), 1);
    check_val("t2_tap", int'(TAP_RESULT), 50);
    check_val("t2_moves", move_cnt, 50);

    // No edge at all: run to the last tap
    m_mode = 2;
    run_train(5000, to);
    check_val("t3_timeout", int'(to), 0);
    check_val("t3_err", int'(TRAIN_ERR), 1);
    check_val("t3_done", int'(TRAIN_DONE), 0);
    check_val("t3_busy", int'(TRAIN_BUSY), 0);
    check_val("t3_tap", int'(TAP_RESULT), 127);
    check_val("t3_moves", move_cnt, 127);

    // Delay line saturates at tap 20
    m_mode = 0; m_oor_tap = 20;
    run_train(2000, to);
    check_val("t4_timeout", int'(to), 0);
    check_val("t4_err", int'(TRAIN_ERR), 1);
    check_val("t4_done", int'(TRAIN_DONE), 0);
    check_val("t4_tap", int'(TAP_RESULT), 20);
    check_val("t4_moves", move_cnt, 20);
    m_oor_tap = -1;
    @(negedge FAB_CLK);

    // Unstable tap 37 counts as zero; edge at 38
    m_mode = 3;
    run_train(2000, to);
    check_val("t5_timeout", int'(to), 0);
    check_val("t5_done", int'(TRAIN_DONE), 1);
    check_val("t5_err", int'(TRAIN_ERR), 0);
    check_val("t5_tap", int'(TAP_RESULT), 38);
    check_val("t5_busy_cycles", busy_cyc, 39 * 30);

    // Mid-sweep START ignored, reset at tap 15 aborts, then a clean rerun
    m_mode = 0;
    load_cnt = 0;
    move_cnt = 0;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge FAB_CLK);
      #1;
      if (m_tap == 15) begin
        reached = 1'b1;
        break;
      end
    end
    check_val("t6_reach_tap15", int'(reached), 1);
    pulse_start();
    repeat (3) @(posedge FAB_CLK);
    #1;
    check_val("t6_start_ignored_loads", load_cnt, 1);
    check_val("t6_start_ignored_busy", int'(TRAIN_BUSY), 1);
    RESET_N = 1'b0;
    @(posedge FAB_CLK);
    #1;
    RESET_N = 1'b1;
    check_reset_outputs("t6_rst");
    snap_moves = move_cnt;
    repeat (100) @(posedge FAB_CLK);
    #1;
    check_val("t6_no_moves_after_rst", move_cnt, snap_moves);
    check_val("t6_no_loads_after_rst", load_cnt, 1);
    run_train(2000, to);
    check_val("t6_timeout", int'(to), 0);
    check_val("t6_done", int'(TRAIN_DONE), 1);
    check_val("t6_tap", int'(TAP_RESULT), 37);
    check_val("t6_moves", move_cnt, 37);
    check_val("t6_loads", load_cnt, 1);

    check_val("done_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
